// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: unified memory port handshake between controller and memory
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RV32I subset sequencer with wait/timeout, illegal trap and retire counter
module multicycle_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    multicycle_controller_if.master       bus,
    input  logic [6:0]                    opcode,
    input  logic [2:0]                    func3,
    input  logic                          zero,
    output logic                          ir_write,
    output logic                          pc_write,
    output logic                          pc_src,
    output logic                          reg_write,
    output logic [1:0]                    mem_to_reg,
    output logic                          alu_src_a,
    output logic [1:0]                    alu_src_b,
    output logic [1:0]                    alu_op,
    output logic [3:0]                    state,
    output logic                          illegal,
    output logic                          bus_err,
    output logic [CNT_W-1:0]              instr_retired
);
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB_ALU   = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JAL      = 4'd11,
        TRAP     = 4'd15
    } state_t;

    state_t        cur, nxt;
    logic [WW-1:0] wait_cnt;
    logic          wait_max, set_ill, set_bus, retire;

    assign state    = cur;
    assign wait_max = wait_cnt == WW'(TIMEOUT - 1);
    assign retire   = nxt == FETCH && cur != FETCH && cur != IDLE;

    // state register; async reset so a pending request drops immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= IDLE;
        else        cur <= nxt;
    end

    // sticky trap flags, retire counter and memory wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal       <= 1'b0;
            bus_err       <= 1'b0;
            instr_retired <= '0;
            wait_cnt      <= '0;
        end else begin
            illegal       <= illegal | set_ill;
            bus_err       <= bus_err | set_bus;
            instr_retired <= instr_retired + CNT_W'(retire);
            wait_cnt      <= (nxt != cur) ? '0 : (bus.mem_req && !bus.mem_ready) ? wait_cnt + 1'b1 : wait_cnt;
        end
    end

    // next-state and state-decoded controls; a ready in the last wait cycle beats the timeout
    always_comb begin
        nxt         = cur;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        bus.mem_sel = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        set_ill     = 1'b0;
        set_bus     = 1'b0;
        case (cur)
            IDLE: nxt = FETCH;
            FETCH: begin
                bus.mem_req = 1'b1;
                alu_src_b   = 2'b01;
                ir_write    = bus.mem_ready;
                pc_write    = bus.mem_ready;
                set_bus     = !bus.mem_ready && wait_max;
                nxt         = bus.mem_ready ? DECODE : wait_max ? TRAP : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b10;
                nxt       = opcode == OP_R ? EXEC_R :
                            opcode == OP_I ? EXEC_I :
                            (opcode == OP_LD || opcode == OP_ST) ? MEM_ADDR :
                            opcode == OP_BR ? BRANCH :
                            opcode == OP_JAL ? JAL : TRAP;
                set_ill   = nxt == TRAP;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = WB_ALU;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = func3 == 3'b000 ? 2'b00 : 2'b10;
                nxt       = WB_ALU;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = opcode == OP_LD ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.mem_sel = 1'b1;
                set_bus     = !bus.mem_ready && wait_max;
                nxt         = bus.mem_ready ? WB_MEM : wait_max ? TRAP : MEM_RD;
            end
            MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.mem_sel = 1'b1;
                set_bus     = !bus.mem_ready && wait_max;
                nxt         = bus.mem_ready ? FETCH : wait_max ? TRAP : MEM_WR;
            end
            WB_ALU: begin
                reg_write = 1'b1;
                nxt       = FETCH;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                nxt        = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_write  = zero;
                pc_src    = 1'b1;
                nxt       = FETCH;
            end
            JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                nxt        = FETCH;
            end
            TRAP: nxt = TRAP;
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed table, random instruction stream and trap/reset corner cases
module tb_multicycle_controller;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic zero = 1'b0;
    logic ir_write, pc_write, pc_src, reg_write, alu_src_a, illegal, bus_err;
    logic [1:0] mem_to_reg, alu_src_b, alu_op;
    logic [3:0] state;
    logic [31:0] instr_retired;
    logic [13:0] ctl;

    multicycle_controller_if bus_i ();

    multicycle_controller #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_i), .opcode(opcode), .func3(func3), .zero(zero),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .illegal(illegal), .bus_err(bus_err), .instr_retired(instr_retired)
    );

    assign ctl = {bus_i.mem_req, bus_i.mem_we, bus_i.mem_sel, ir_write, pc_write, pc_src,
                  reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op};

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [13:0] ctl;
        logic        rdy;
    } step_t;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        z;
        int          fd;
        int          md;
        logic [31:0] trace;
        int          n;
    } vec_t;

    step_t q[$];
    vec_t  tbl[11];
    int    checks = 0, failures = 0;
    int    exp_ret = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] mk(bit req, bit we, bit sel, bit irw, bit pcw, bit pcs, bit rw,
                                       bit [1:0] m2r, bit a, bit [1:0] b, bit [1:0] op);
        return {req, we, sel, irw, pcw, pcs, rw, m2r, a, b, op};
    endfunction

    function automatic logic dc();
        return 1'($urandom_range(0, 1));
    endfunction

    // instruction-level reference: expected per-cycle state/controls and the ready the bench drives
    task automatic plan(input logic [6:0] op, input logic [2:0] f3, input logic z, input int fd, input int md);
        q.delete();
        for (int i = 0; i < fd; i++) q.push_back('{4'd1, mk(1,0,0,0,0,0,0,2'd0,0,2'd1,2'd0), 1'b0});
        q.push_back('{4'd1, mk(1,0,0,1,1,0,0,2'd0,0,2'd1,2'd0), 1'b1});
        q.push_back('{4'd2, mk(0,0,0,0,0,0,0,2'd0,0,2'd2,2'd0), dc()});
        if (op == OP_R) begin
            q.push_back('{4'd3, mk(0,0,0,0,0,0,0,2'd0,1,2'd0,2'd2), dc()});
            q.push_back('{4'd8, mk(0,0,0,0,0,0,1,2'd0,0,2'd0,2'd0), dc()});
        end else if (op == OP_I) begin
            q.push_back('{4'd4, mk(0,0,0,0,0,0,0,2'd0,1,2'd2, f3 == 3'd0 ? 2'd0 : 2'd2), dc()});
            q.push_back('{4'd8, mk(0,0,0,0,0,0,1,2'd0,0,2'd0,2'd0), dc()});
        end else if (op == OP_LD) begin
            q.push_back('{4'd5, mk(0,0,0,0,0,0,0,2'd0,1,2'd2,2'd0), dc()});
            for (int i = 0; i < md; i++) q.push_back('{4'd6, mk(1,0,1,0,0,0,0,2'd0,0,2'd0,2'd0), 1'b0});
            q.push_back('{4'd6, mk(1,0,1,0,0,0,0,2'd0,0,2'd0,2'd0), 1'b1});
            q.push_back('{4'd9, mk(0,0,0,0,0,0,1,2'd1,0,2'd0,2'd0), dc()});
        end else if (op == OP_ST) begin
            q.push_back('{4'd5, mk(0,0,0,0,0,0,0,2'd0,1,2'd2,2'd0), dc()});
            for (int i = 0; i < md; i++) q.push_back('{4'd7, mk(1,1,1,0,0,0,0,2'd0,0,2'd0,2'd0), 1'b0});
            q.push_back('{4'd7, mk(1,1,1,0,0,0,0,2'd0,0,2'd0,2'd0), 1'b1});
        end else if (op == OP_BR) begin
            q.push_back('{4'd10, mk(0,0,0,0,z,1,0,2'd0,1,2'd0,2'd1), dc()});
        end else begin
            q.push_back('{4'd11, mk(0,0,0,0,1,1,1,2'd2,0,2'd0,2'd0), dc()});
        end
    endtask

    // run one legal instruction from FETCH back to FETCH, optionally also against a hand trace
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z, input int fd,
                             input int md, input logic [31:0] trace, input int n);
        plan(op, f3, z, fd, md);
        opcode = op;
        func3  = f3;
        zero   = z;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            bus_i.mem_ready = q[i].rdy;
            #1;
            chk("state", 32'(state), 32'(q[i].st));
            chk("ctl", 32'(ctl), 32'(q[i].ctl));
            if (n > 0) chk("trace", 32'(state), (trace >> (4 * (n - 1 - i))) & 32'hF);
        end
        @(posedge clk);
        #1;
        exp_ret++;
        chk("retired", instr_retired, 32'(exp_ret));
        chk("flags", {30'd0, illegal, bus_err}, 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_ret = 0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_flags", {30'd0, illegal, bus_err}, 32'd0);
        chk("rst_retired", instr_retired, 32'd0);
        chk("rst_ctl", 32'(ctl), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops[6];
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL};
        tbl[0]  = '{OP_R,   3'd0, 1'b0, 0, 0,  32'h1238,    4};
        tbl[1]  = '{OP_I,   3'd0, 1'b0, 0, 0,  32'h1248,    4};
        tbl[2]  = '{OP_I,   3'd4, 1'b0, 2, 0,  32'h111248,  6};
        tbl[3]  = '{OP_LD,  3'd2, 1'b0, 0, 2,  32'h1256669, 7};
        tbl[4]  = '{OP_ST,  3'd2, 1'b0, 0, 0,  32'h1257,    4};
        tbl[5]  = '{OP_ST,  3'd2, 1'b1, 1, 1,  32'h112577,  6};
        tbl[6]  = '{OP_BR,  3'd0, 1'b1, 0, 0,  32'h12A,     3};
        tbl[7]  = '{OP_BR,  3'd0, 1'b0, 0, 0,  32'h12A,     3};
        tbl[8]  = '{OP_JAL, 3'd0, 1'b0, 0, 0,  32'h12B,     3};
        tbl[9]  = '{OP_LD,  3'd2, 1'b0, 0, 15, 32'h0,       0};
        tbl[10] = '{OP_R,   3'd0, 1'b0, 15, 0, 32'h0,       0};
        bus_i.mem_ready = 1'b0;
        #12;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_ctl", 32'(ctl), 32'd0);
        chk("reset_flags", {30'd0, illegal, bus_err}, 32'd0);
        chk("reset_retired", instr_retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++)
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].z, tbl[i].fd, tbl[i].md, tbl[i].trace, tbl[i].n);
        for (int i = 0; i < 40; i++) begin
            int fd, md;
            fd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            md = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), fd, md, 32'h0, 0);
        end
        opcode = 7'b1111111;
        @(negedge clk);
        bus_i.mem_ready = 1'b1;
        #1;
        chk("ill_fetch", 32'(state), 32'd1);
        @(negedge clk);
        bus_i.mem_ready = 1'b0;
        #1;
        chk("ill_decode", 32'(state), 32'd2);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            bus_i.mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("ill_trap", {state, ctl, illegal, bus_err}, {4'd15, 14'd0, 1'b1, 1'b0});
        end
        chk("ill_retired", instr_retired, 32'(exp_ret));
        reset_pulse();
        opcode = OP_R;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus_i.mem_ready = 1'b0;
            #1;
            chk("to_fetch", 32'(state), 32'd1);
        end
        @(negedge clk);
        #1;
        chk("to_trap", {state, ctl, illegal, bus_err}, {4'd15, 14'd0, 1'b0, 1'b1});
        chk("to_retired", instr_retired, 32'd0);
        reset_pulse();
        run_instr(OP_R, 3'd0, 1'b0, 0, 0, 32'h1238, 4);
        opcode = OP_ST;
        @(negedge clk);
        bus_i.mem_ready = 1'b1;
        @(negedge clk);
        bus_i.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("wr_active", {state, bus_i.mem_req, bus_i.mem_we}, {4'd7, 1'b1, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        chk("wr_async", {state, ctl, instr_retired}, {4'd0, 14'd0, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("wr_idle", 32'(state), 32'd0);
        @(negedge clk);
        #1;
        chk("wr_fetch", 32'(state), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencing FSM for the RV32I core subset: R-type ALU, I-type ALU, LW, SW, branches and JAL.
- Drives one shared ALU, one unified memory port and the PC/IR/register-file enables across several cycles per instruction.
- Sits beside the datapath and replaces single-cycle decoding for the shared-memory build.
- Adds memory wait handling, a bus timeout trap, an illegal-opcode trap and a retired-instruction counter.

Parameters:
- TIMEOUT, 16, maximum consecutive wait cycles on a memory request before a bus-error trap (must be at least 2).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- func3  in  3  IR[14:12].
- zero  in  1  ALU zero flag, combinational from the datapath.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request strobe.
- mem_we  out  1  write enable for the request.
- mem_sel  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut register.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  2  writeback select: 00 = ALUOut, 01 = MDR, 10 = PC+4.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  ALU op class: 00 = add, 01 = subtract/compare, 10 = use func fields.
- state  out  4  current state, for debug.
- illegal  out  1  sticky illegal-opcode flag.
- bus_err  out  1  sticky memory-timeout flag.
- instr_retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset:
  - Asynchronous on rst_n low; state = IDLE.
  - illegal, bus_err and instr_retired clear to 0.
  - Every decoded output is 0 while in IDLE.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, JAL=11, TRAP=15.
- Outputs are decoded from state; any output not listed for a state is 0. The only Mealy terms are the FETCH mem_ready terms and the BRANCH pc_write.
- IDLE: goes to FETCH on the first clock after reset is released.
- FETCH:
  - mem_req=1, mem_sel=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - When mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE. Otherwise stay.
- DECODE:
  - alu_src_a=0, alu_src_b=10, alu_op=00 (branch/jump target computed into ALUOut).
  - Next state by opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> MEM_ADDR; 1100011 -> BRANCH; 1101111 -> JAL; any other value -> TRAP with illegal set to 1.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10; alu_op=00 if func3==000, else 10; next WB_ALU.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_RD if opcode==0000011, else MEM_WR.
- MEM_RD: mem_req=1, mem_sel=1; on mem_ready go to WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, mem_sel=1; on mem_ready go to FETCH and retire.
- WB_ALU: reg_write=1, mem_to_reg=00; next FETCH, retire.
- WB_MEM: reg_write=1, mem_to_reg=01; next FETCH, retire.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01.
  - pc_write=zero with pc_src=1 (BEQ semantics only; other func3 values are not decoded here).
  - Next FETCH, retire.
- JAL: reg_write=1, mem_to_reg=10, pc_write=1, pc_src=1; next FETCH, retire.
- Retire: instr_retired increments by 1 on the transition into FETCH from MEM_WR, WB_ALU, WB_MEM, BRANCH or JAL. The counter wraps modulo 2^CNT_W.
- Timeout:
  - A wait counter clears on entry to FETCH, MEM_RD or MEM_WR.
  - It increments each cycle mem_req=1 and mem_ready=0.
  - If it reaches TIMEOUT-1 with mem_ready still 0, go to TRAP with bus_err set to 1.
  - If mem_ready arrives in that same cycle, mem_ready wins and no trap occurs.
- TRAP: all outputs 0; illegal and bus_err hold their values; leaves only on reset.
- Reset mid-request drops mem_req immediately and asynchronously; no partial PC, IR or register write is issued.

Test Plan:
- ADD x3,x1,x2 with mem_ready tied 1 -> states 1,2,3,8,1; reg_write=1 for exactly one cycle (WB_ALU); instr_retired=1.
- LW with mem_ready delayed 3 cycles in MEM_RD -> state holds 6 for 3 cycles, then 9 with mem_to_reg=01; total 8 cycles from FETCH to FETCH.
- BEQ with zero=1, then zero=0 -> pc_write=1 / pc_src=1 in BRANCH for the first, pc_write=0 for the second; both retire (count +2).
- Opcode 1111111 -> DECODE goes to TRAP, illegal=1, all enables 0 for 20+ cycles; rst_n pulse returns to IDLE and clears illegal.
- FETCH with mem_ready held 0, TIMEOUT=16 -> TRAP entered after 16 cycles in FETCH, bus_err=1, instr_retired unchanged.
- rst_n asserted mid-MEM_WR -> mem_req and mem_we fall asynchronously; after release, sequence is IDLE then FETCH.
